light_decode: RTL and testbench
===============================

LIGHT_DECODE -- requirements
Module: light_decode

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, consecutive identical samples needed to accept a code (range 1..15).
REQ-002 SHALL have parameter BLINK_HALF, default 8, clock cycles per blink half-period (range 1..255).
REQ-003 SHALL have port CLK  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port RST_N  input  1  synchronous, active-low reset.
REQ-005 SHALL have port light  input  4  status code from the controller's light encoder.
REQ-006 SHALL have port mode  output  3  accepted mode: 0 LOCK, 1 IDLE0, 2 IDLE1, 3 SETTING, 4 WORK0, 5 WORK1, 7 FAULT.
REQ-007 SHALL have port mode_valid  output  1  high while a legal code is accepted (state LOCKED).
REQ-008 SHALL have port mode_change  output  1  one-cycle pulse when the accepted mode changes.
REQ-009 SHALL have port led_work  output  1  work indicator.
REQ-010 SHALL have port led_set  output  1  set indicator.
REQ-011 SHALL have port led_err  output  1  fault indicator.

Function
REQ-012 SHALL map legal codes: 0000->LOCK, 0001->IDLE0, 0010->IDLE1, 0011->SETTING, 0100->WORK0, 0101->WORK1; codes 0110..1111 SHALL be illegal.
REQ-013 SHALL register light once (stage cand) and keep a stability counter: equal to cand -> increment, saturating at STABLE_CYCLES; different -> load cand, counter=1.
REQ-014 SHALL use FSM states ACQUIRE, LOCKED, FAULT.
REQ-015 ACQUIRE: when counter reaches STABLE_CYCLES, SHALL go to LOCKED if cand is legal, or to FAULT if it is illegal.
REQ-016 LOCKED: when a stable legal code differs from mode, SHALL update mode and pulse mode_change in the same cycle; a stable illegal code SHALL go to FAULT.
REQ-017 LOCKED: a code change not yet stable SHALL leave mode unchanged and SHALL NOT return to ACQUIRE.
REQ-018 FAULT: mode=7, mode_valid=0; a stable legal code SHALL go to LOCKED with mode updated and mode_change pulsed.
REQ-019 Entering FAULT from LOCKED SHALL pulse mode_change; the first ACQUIRE->LOCKED or ACQUIRE->FAULT transition SHALL also pulse it.
REQ-020 Latency: a code held from cycle t SHALL appear on mode at edge t+STABLE_CYCLES+1.
REQ-021 Blink generator: an 8-bit counter counts 0..BLINK_HALF-1 and wraps; blink toggles at each wrap; counter and blink SHALL be cleared on every mode_change.
REQ-022 led_work SHALL be 1 in WORK0/WORK1, else 0.
REQ-023 led_set SHALL equal blink in SETTING, be 1 in IDLE1/WORK1, else 0.
REQ-024 led_err SHALL equal blink in FAULT, else 0.
REQ-025 In LOCK mode all LEDs SHALL be 0 with mode_valid=1.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 With RST_N=0 at an edge: state=ACQUIRE, cand=0000, counter=0, mode=0, mode_valid=0, mode_change=0, all LEDs 0, blink counter=0.
REQ-028 Reset mid-operation SHALL discard any partial stability count; acquisition restarts from the first post-reset sample.

Structure
REQ-029 A shared package SHALL hold the mode enum (3-bit values above), the FSM state enum, and the legal light code constants, shared with the light encoder.
REQ-030 The blink generator SHALL be one sub-module, blink_gen (ports CLK, RST_N, clr, blink).

Verification
REQ-031 Reset then light=0100 held -> mode=4, mode_valid=1, mode_change pulse, led_work=1 at the 5th edge after the first sample.
REQ-032 LOCKED in WORK0, light glitches to 0101 for 2 cycles then back to 0100 -> mode stays 4, no mode_change.
REQ-033 light=0011 held -> mode=3, led_set toggles every 8 cycles, led_work=0.
REQ-034 light=1010 held from LOCKED -> mode=7, mode_valid=0, led_err blinks; then 0001 held -> mode=1, led_err=0.
REQ-035 Mid-acquisition (counter=3), RST_N=0 for one cycle -> all outputs at reset values; acquisition restarts.
REQ-036 light=0000 held -> mode=0, mode_valid=1, all LEDs 0.

Source files
------------

// File: rtl/light_decode_pkg.sv
// Shared definitions for the light decoder: accepted modes, decoder FSM states
// and the status codes produced by the controller's light encoder.
package light_decode_pkg;

    typedef enum logic [2:0] {
        MODE_LOCK    = 3'd0,
        MODE_IDLE0   = 3'd1,
        MODE_IDLE1   = 3'd2,
        MODE_SETTING = 3'd3,
        MODE_WORK0   = 3'd4,
        MODE_WORK1   = 3'd5,
        MODE_FAULT   = 3'd7
    } mode_t;

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    localparam logic [3:0] LIGHT_LOCK    = 4'b0000;
    localparam logic [3:0] LIGHT_IDLE0   = 4'b0001;
    localparam logic [3:0] LIGHT_IDLE1   = 4'b0010;
    localparam logic [3:0] LIGHT_SETTING = 4'b0011;
    localparam logic [3:0] LIGHT_WORK0   = 4'b0100;
    localparam logic [3:0] LIGHT_WORK1   = 4'b0101;

    function automatic logic light_legal(input logic [3:0] code);
        case (code)
            LIGHT_LOCK, LIGHT_IDLE0, LIGHT_IDLE1,
            LIGHT_SETTING, LIGHT_WORK0, LIGHT_WORK1: light_legal = 1'b1;
            default:                                 light_legal = 1'b0;
        endcase
    endfunction

    function automatic mode_t light_to_mode(input logic [3:0] code);
        case (code)
            LIGHT_LOCK:    light_to_mode = MODE_LOCK;
            LIGHT_IDLE0:   light_to_mode = MODE_IDLE0;
            LIGHT_IDLE1:   light_to_mode = MODE_IDLE1;
            LIGHT_SETTING: light_to_mode = MODE_SETTING;
            LIGHT_WORK0:   light_to_mode = MODE_WORK0;
            LIGHT_WORK1:   light_to_mode = MODE_WORK1;
            default:       light_to_mode = MODE_FAULT;
        endcase
    endfunction

endpackage

// File: rtl/light_decode_blink_gen.sv
// Free-running blink source: toggles every BLINK_HALF cycles, restarts low on clr.
module blink_gen #(
    parameter int BLINK_HALF = 8
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clr,
    output logic blink
);

    localparam logic [7:0] LAST = 8'(BLINK_HALF - 1);

    logic [7:0] cnt;

    always_ff @(posedge CLK) begin
        if (!RST_N || clr) begin
            cnt   <= 8'd0;
            blink <= 1'b0;
        end else if (cnt == LAST) begin
            cnt   <= 8'd0;
            blink <= ~blink;
        end else begin
            cnt   <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/light_decode.sv
// Debounces the 4-bit status light code, tracks the accepted mode and drives
// the work/set/fault indicator LEDs. fsm_state exposes the decoder FSM.
module light_decode
    import light_decode_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int BLINK_HALF    = 8
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] light,
    output logic [2:0] mode,
    output logic       mode_valid,
    output logic       mode_change,
    output logic       led_work,
    output logic       led_set,
    output logic       led_err,
    output state_t     fsm_state
);

    localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

    logic [3:0] cand;
    logic [3:0] cnt;
    state_t     state;
    state_t     state_nx;
    mode_t      mode_q;
    mode_t      mode_nx;
    mode_t      cand_mode;
    logic       change_nx;
    logic       stable;
    logic       legal;
    logic       blink;

    // Stability tracker: counts consecutive identical samples of light.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cand <= 4'd0;
            cnt  <= 4'd0;
        end else begin
            cand <= light;
            if (light == cand) begin
                if (cnt != STABLE) cnt <= cnt + 4'd1;
            end else begin
                cnt <= 4'd1;
            end
        end
    end

    assign stable    = (cnt == STABLE);
    assign legal     = light_legal(cand);
    assign cand_mode = light_to_mode(cand);

    always_comb begin
        state_nx  = state;
        mode_nx   = mode_q;
        change_nx = 1'b0;
        case (state)
            ST_ACQUIRE: begin
                if (stable) begin
                    change_nx = 1'b1;
                    if (legal) begin
                        state_nx = ST_LOCKED;
                        mode_nx  = cand_mode;
                    end else begin
                        state_nx = ST_FAULT;
                        mode_nx  = MODE_FAULT;
                    end
                end
            end
            ST_LOCKED: begin
                // Unstable codes are ignored here; only a settled code moves us.
                if (stable) begin
                    if (!legal) begin
                        state_nx  = ST_FAULT;
                        mode_nx   = MODE_FAULT;
                        change_nx = 1'b1;
                    end else if (cand_mode != mode_q) begin
                        mode_nx   = cand_mode;
                        change_nx = 1'b1;
                    end
                end
            end
            ST_FAULT: begin
                if (stable && legal) begin
                    state_nx  = ST_LOCKED;
                    mode_nx   = cand_mode;
                    change_nx = 1'b1;
                end
            end
            default: begin
                state_nx = ST_ACQUIRE;
                mode_nx  = MODE_LOCK;
            end
        endcase
    end

    blink_gen #(
        .BLINK_HALF(BLINK_HALF)
    ) u_blink (
        .CLK  (CLK),
        .RST_N(RST_N),
        .clr  (change_nx),
        .blink(blink)
    );

    // LEDs follow the next mode; blink is forced low on the edge it is cleared.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= ST_ACQUIRE;
            mode_q      <= MODE_LOCK;
            mode_valid  <= 1'b0;
            mode_change <= 1'b0;
            led_work    <= 1'b0;
            led_set     <= 1'b0;
            led_err     <= 1'b0;
        end else begin
            state       <= state_nx;
            mode_q      <= mode_nx;
            mode_valid  <= (state_nx == ST_LOCKED);
            mode_change <= change_nx;
            led_work    <= (mode_nx == MODE_WORK0) || (mode_nx == MODE_WORK1);
            led_set     <= (mode_nx == MODE_SETTING) ? (blink && !change_nx)
                         : ((mode_nx == MODE_IDLE1) || (mode_nx == MODE_WORK1));
            led_err     <= (mode_nx == MODE_FAULT) && blink && !change_nx;
        end
    end

    assign mode      = mode_q;
    assign fsm_state = state;

endmodule

// File: tb/tb_light_decode.sv
// Self-checking bench for light_decode: a sample-history model predicts every
// output cycle, predictions queue up at each edge and are compared at negedge.
module tb_light_decode;
    import light_decode_pkg::*;

    localparam int S    = 4;
    localparam int HALF = 8;

    logic       CLK;
    logic       RST_N;
    logic [3:0] light;
    logic [2:0] mode;
    logic       mode_valid;
    logic       mode_change;
    logic       led_work;
    logic       led_set;
    logic       led_err;
    state_t     fsm_state;

    light_decode #(
        .STABLE_CYCLES(S),
        .BLINK_HALF   (HALF)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .light      (light),
        .mode       (mode),
        .mode_valid (mode_valid),
        .mode_change(mode_change),
        .led_work   (led_work),
        .led_set    (led_set),
        .led_err    (led_err),
        .fsm_state  (fsm_state)
    );

    // Clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [9:0]  exp_q[$];
    string       phase = "init";

    logic [3:0]  m_hist[$];
    state_t      m_state;
    logic [2:0]  m_mode;
    logic        m_change;
    int          m_since;

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got={st,mode,v,chg,work,set,err}=%b expected=%b at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic push_expected();
        logic blink_led;
        logic work;
        logic set;
        logic err;
        blink_led = (!m_change && m_since >= 1) ? (((m_since - 1) / HALF) % 2 == 1) : 1'b0;
        work = (m_mode == 3'd4) || (m_mode == 3'd5);
        set  = (m_mode == 3'd3) ? blink_led : ((m_mode == 3'd2) || (m_mode == 3'd5));
        err  = (m_mode == 3'd7) ? blink_led : 1'b0;
        exp_q.push_back({m_state, m_mode, (m_state == ST_LOCKED), m_change, work, set, err});
    endtask

    // Driver tasks
    task automatic do_reset(input int n);
        RST_N = 1'b0;
        repeat (n) begin
            @(posedge CLK);
            m_hist.delete();
            m_state  = ST_ACQUIRE;
            m_mode   = 3'd0;
            m_change = 1'b0;
            m_since  = 0;
            push_expected();
            #1;
        end
        RST_N = 1'b1;
    endtask

    task automatic step(input logic [3:0] code);
        logic       stable;
        logic [3:0] c;
        logic       legal;
        light = code;
        @(posedge CLK);
        stable = (m_hist.size() == S);
        if (stable) begin
            foreach (m_hist[i]) if (m_hist[i] != m_hist[0]) stable = 1'b0;
        end
        m_change = 1'b0;
        if (stable) begin
            c     = m_hist[0];
            legal = (c <= 4'd5);
            case (m_state)
                ST_ACQUIRE: begin
                    m_change = 1'b1;
                    m_state  = legal ? ST_LOCKED : ST_FAULT;
                    m_mode   = legal ? c[2:0] : 3'd7;
                end
                ST_LOCKED: begin
                    if (!legal) begin
                        m_state  = ST_FAULT;
                        m_mode   = 3'd7;
                        m_change = 1'b1;
                    end else if (c[2:0] != m_mode) begin
                        m_mode   = c[2:0];
                        m_change = 1'b1;
                    end
                end
                default: begin
                    if (legal) begin
                        m_state  = ST_LOCKED;
                        m_mode   = c[2:0];
                        m_change = 1'b1;
                    end
                end
            endcase
        end
        m_hist.push_back(code);
        if (m_hist.size() > S) void'(m_hist.pop_front());
        if (m_change) m_since = 0;
        else          m_since++;
        push_expected();
        #1;
    endtask

    task automatic hold(input logic [3:0] code, input int n);
        repeat (n) step(code);
    endtask

    // Scoreboard: compare each queued prediction against the DUT at negedge
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            check(phase, {fsm_state, mode, mode_valid, mode_change, led_work, led_set, led_err},
                  exp_q.pop_front());
        end
    end

    initial begin
        RST_N = 1'b0;
        light = 4'd0;
        phase = "reset";
        do_reset(2);

        phase = "acquire_work0";
        hold(4'b0100, 10);

        phase = "glitch_work1";
        hold(4'b0101, 2);
        hold(4'b0100, 8);

        phase = "setting_blink";
        hold(4'b0011, 40);

        phase = "fault_blink";
        hold(4'b1010, 30);

        phase = "recover_idle0";
        hold(4'b0001, 10);

        phase = "work1";
        hold(4'b0101, 8);

        phase = "idle1";
        hold(4'b0010, 8);

        phase = "partial_then_reset";
        hold(4'b0100, 3);
        do_reset(1);
        phase = "reacquire";
        hold(4'b0100, 8);

        phase = "lock";
        hold(4'b0000, 10);

        phase = "acquire_illegal";
        do_reset(1);
        hold(4'b1111, 8);
        hold(4'b0011, 8);

        phase = "random";
        repeat (25) begin
            logic [3:0] code;
            code = 4'($urandom_range(0, 9));
            if (code == 4'd9) code = 4'b1111;
            hold(code, $urandom_range(1, 7));
        end

        phase = "drain";
        @(negedge CLK);
        #1;
        check("queue_drained", 10'(exp_q.size()), 10'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
